regfile_wb_arbiter: RTL and testbench

//  Arbitrates two writeback sources onto the single register-file write port: ALU (A) and load/store unit (B).

---
 rtl/rv_core_pkg.sv | 8 +
 rtl/wb_scoreboard.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 78 +++++++
 tb/tb_regfile_wb_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared core widths and writeback arbiter state encoding
package rv_core_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] REG_ZERO = '0;
    typedef enum logic {PRI_A, PRI_B} arb_state_e;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write tracking for RAW/WAW hazard detection
module wb_scoreboard
    import rv_core_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic          clr_valid,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy
);
    logic [NREG-1:0] busy_q, busy_d;
    logic            set_en;

    assign issue_ready = !busy_q[issue_rd];
    assign set_en      = issue_valid && issue_ready && issue_rd != REG_ZERO;
    // A writeback accepted this cycle lands in the register file by the next edge.
    assign rs1_busy    = busy_q[rs1] && !(clr_valid && clr_rd == rs1);
    assign rs2_busy    = busy_q[rs2] && !(clr_valid && clr_rd == rs2);

    always_comb begin
        busy_d = busy_q;
        if (clr_valid) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/LSU writeback arbitration onto the register-file port
module regfile_wb_arbiter
    import rv_core_pkg::*;
(
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iA_VALID,
    output logic            oA_READY,
    input  logic [AW-1:0]   iA_RD,
    input  logic [XLEN-1:0] iA_DATA,
    input  logic            iB_VALID,
    output logic            oB_READY,
    input  logic [AW-1:0]   iB_RD,
    input  logic [XLEN-1:0] iB_DATA,
    input  logic            iISSUE_VALID,
    input  logic [AW-1:0]   iISSUE_RD,
    output logic            oISSUE_READY,
    input  logic [AW-1:0]   iRS1,
    input  logic [AW-1:0]   iRS2,
    output logic            oRS1_BUSY,
    output logic            oRS2_BUSY,
    output logic [AW-1:0]   oRF_RD,
    output logic [XLEN-1:0] oRF_DATA,
    output logic            oRF_WE
);
    arb_state_e      state_q, state_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d, acc_rd;
    logic [XLEN-1:0] rf_data_q, rf_data_d, acc_data;
    logic            rf_we_q, rf_we_d, grant_a, grant_b, acc_valid;

    assign grant_a   = iA_VALID && (!iB_VALID || state_q == PRI_A);
    assign grant_b   = iB_VALID && (!iA_VALID || state_q == PRI_B);
    assign oA_READY  = grant_a;
    assign oB_READY  = grant_b;
    assign acc_valid = grant_a || grant_b;
    assign acc_rd    = grant_a ? iA_RD : iB_RD;
    assign acc_data  = grant_a ? iA_DATA : iB_DATA;

    // Port parks on x0/0 when idle or when the accepted write targets x0.
    always_comb begin
        state_d   = grant_a ? PRI_B : grant_b ? PRI_A : state_q;
        rf_we_d   = acc_valid && acc_rd != REG_ZERO;
        rf_rd_d   = rf_we_d ? acc_rd : REG_ZERO;
        rf_data_d = rf_we_d ? acc_data : '0;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= PRI_A;
            rf_rd_q   <= REG_ZERO;
            rf_data_q <= '0;
            rf_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            rf_we_q   <= rf_we_d;
        end
    end

    assign oRF_RD   = rf_rd_q;
    assign oRF_DATA = rf_data_q;
    assign oRF_WE   = rf_we_q;

    wb_scoreboard u_sb (
        .clk         (iCLK),
        .rst         (iRST),
        .issue_valid (iISSUE_VALID),
        .issue_rd    (iISSUE_RD),
        .issue_ready (oISSUE_READY),
        .clr_valid   (acc_valid),
        .clr_rd      (acc_rd),
        .rs1         (iRS1),
        .rs2         (iRS2),
        .rs1_busy    (oRS1_BUSY),
        .rs2_busy    (oRS2_BUSY)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, output register and scoreboard
module tb_regfile_wb_arbiter;
    logic        clk, rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2, rf_rd;
    logic [31:0] a_data, b_data, rf_data;
    logic        issue_valid, issue_ready, rs1_busy, rs2_busy, rf_we;
    int          tests = 0, fails = 0;

    regfile_wb_arbiter dut (
        .iCLK(clk), .iRST(rst),
        .iA_VALID(a_valid), .oA_READY(a_ready), .iA_RD(a_rd), .iA_DATA(a_data),
        .iB_VALID(b_valid), .oB_READY(b_ready), .iB_RD(b_rd), .iB_DATA(b_data),
        .iISSUE_VALID(issue_valid), .iISSUE_RD(issue_rd), .oISSUE_READY(issue_ready),
        .iRS1(rs1), .iRS2(rs2), .oRS1_BUSY(rs1_busy), .oRS2_BUSY(rs2_busy),
        .oRF_RD(rf_rd), .oRF_DATA(rf_data), .oRF_WE(rf_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        {a_valid, b_valid, issue_valid} = '0;
        {a_rd, b_rd, issue_rd, rs1, rs2} = '0;
        {a_data, b_data} = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", rf_rd, 0);
        check("rst_data", rf_data, 0);
        check("rst_we", rf_we, 0);
        rst = 1'b0;

        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        #1;
        check("a_only_ready", a_ready, 1);
        check("a_only_b_ready", b_ready, 0);
        step();
        a_valid = 0;
        check("a_only_rd", rf_rd, 5);
        check("a_only_data", rf_data, 32'hDEADBEEF);
        check("a_only_we", rf_we, 1);
        step();
        check("idle_we", rf_we, 0);
        check("idle_rd", rf_rd, 0);
        check("idle_data", rf_data, 0);

        do_reset();
        a_valid = 1; a_rd = 1; a_data = 32'h11;
        b_valid = 1; b_rd = 2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
            step();
            check("rr_rd", rf_rd, (i % 2 == 0) ? 1 : 2);
            check("rr_data", rf_data, (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        a_valid = 0; b_valid = 0;

        issue_valid = 1; issue_rd = 7;
        #1;
        check("issue7_ready", issue_ready, 1);
        step();
        issue_valid = 0; rs1 = 7;
        #1;
        check("rs1_busy_set", rs1_busy, 1);
        issue_valid = 1;
        #1;
        check("issue7_waw", issue_ready, 0);
        step();
        issue_valid = 0;
        b_valid = 1; b_rd = 7; b_data = 32'h77;
        #1;
        check("b7_ready", b_ready, 1);
        check("rs1_inflight", rs1_busy, 0);
        step();
        b_valid = 0;
        #1;
        check("b7_rd", rf_rd, 7);
        check("rs1_cleared", rs1_busy, 0);
        check("issue7_free", issue_ready, 1);

        a_valid = 1; a_rd = 0; a_data = 32'h1234;
        #1;
        check("x0_ready", a_ready, 1);
        step();
        a_valid = 0;
        check("x0_rd", rf_rd, 0);
        check("x0_data", rf_data, 0);
        check("x0_we", rf_we, 0);

        issue_valid = 1; issue_rd = 3; rs2 = 3;
        a_valid = 1; a_rd = 3; a_data = 32'h33;
        #1;
        check("set_clr_a_ready", a_ready, 1);
        check("set_clr_rs2_pre", rs2_busy, 0);
        step();
        issue_valid = 0; a_valid = 0;
        #1;
        check("set_wins_rs2", rs2_busy, 1);
        check("set_wins_issue", issue_ready, 0);

        a_valid = 1; a_rd = 9; a_data = 32'hAA;
        step();
        check("pre_rst_rd", rf_rd, 9);
        #2 rst = 1;
        #1;
        check("mid_rst_rd", rf_rd, 0);
        check("mid_rst_data", rf_data, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_rs2", rs2_busy, 0);
        check("mid_rst_issue", issue_ready, 1);
        @(posedge clk);
        a_rd = 4; a_data = 32'h44;
        b_valid = 1; b_rd = 6; b_data = 32'h66;
        #1 rst = 0;
        #1;
        check("post_rst_a_ready", a_ready, 1);
        check("post_rst_b_ready", b_ready, 0);
        step();
        check("post_rst_rd", rf_rd, 4);
        a_valid = 0;
        #1;
        check("b_waits_one", b_ready, 1);
        b_valid = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
